// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of nibble passes for a given width; 0 flags a width that is not nibble-aligned.
  function automatic int unsigned nib_count(input int unsigned width);
    return ((width % NIB_W) == 0) ? (width / NIB_W) : 0;
  endfunction

endpackage

// File: rtl/cla_seq_adder_cla.sv
// 4-bit carry-lookahead adder slice; purely combinational.
module cla_seq_adder_cla
  import cla_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             c_i,
  output logic [NIB_W-1:0] s_o,
  output logic             c_o
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Fully expanded lookahead carries.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial adder: one shared 4-bit CLA slice walks the operands LSB-first.
// Define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB   = nib_count(WIDTH);
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((NIB == 0) || (WIDTH < 8)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e                      state_q;
  logic [NIB-1:0][NIB_W-1:0]   a_q;
  logic [NIB-1:0][NIB_W-1:0]   b_q;
  logic [NIB-1:0][NIB_W-1:0]   sum_q;
  logic                        carry_q;
  logic                        cout_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic [NIB_W-1:0]            a_nib_c;
  logic [NIB_W-1:0]            b_nib_c;
  logic [NIB_W-1:0]            nib_sum_c;
  logic                        nib_co_c;
  logic                        last_c;

  assign a_nib_c = a_q[cnt_q];
  assign b_nib_c = b_q[cnt_q];
  assign cnt_d   = cnt_q + CNT_W'(1);
  assign last_c  = (cnt_q == CNT_W'(NIB - 1));

  cla_seq_adder_cla u_cla (
    .a_i (a_nib_c),
    .b_i (b_nib_c),
    .c_i (carry_q),
    .s_o (nib_sum_c),
    .c_o (nib_co_c)
  );

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q;
  logic c3_c;

  // Carry into the nibble's bit 3; on the last pass this is the carry into the MSB.
  always_comb begin
    c3_c = carry_q;
    for (int i = 0; i < 3; i++) begin
      c3_c = (a_nib_c[i] & b_nib_c[i]) | ((a_nib_c[i] ^ b_nib_c[i]) & c3_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state_q == IDLE) && in_valid) begin
      ovf_q <= 1'b0;
    end else if ((state_q == RUN) && last_c) begin
      ovf_q <= c3_c ^ nib_co_c;
    end
  end

  assign ovf = ovf_q;
`endif

  // Control FSM and datapath registers; operand registers are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[cnt_q] <= nib_sum_c;
          carry_q      <= nib_co_c;
          if (last_c) begin
            cout_q  <= nib_co_c;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder (WIDTH=16); ovf checked when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t hold_e;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   busy_n;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mc);
    logic [WIDTH:0] t;
    exp_t m;
    t      = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
    m.sum  = t[WIDTH-1:0];
    m.cout = t[WIDTH];
    m.ovf  = (ma[WIDTH-1] == mb[WIDTH-1]) && (t[WIDTH-1] != ma[WIDTH-1]);
    return m;
  endfunction

  // Output monitor: pop one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("sum", 32'(sum), 32'(mon_e.sum));
        check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef CLA_SEQ_OVF_EN
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
    int n = 0;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(model(ta, tb_v, tc));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l, output int bn);
    l  = 0;
    bn = 0;
    while (!out_valid && l < 20) begin
      bn += int'(busy);
      @(posedge clk); #1;
      l++;
    end
    bn += int'(busy);
  endtask

  // Full op with consumer ready: latency, busy span and in_ready one cycle after the handshake.
  task automatic op_full(input string tag, input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb_v, input logic tc);
    int l;
    int bn;
    send(ta, tb_v, tc);
    wait_done(l, bn);
    check({tag, "_latency"}, 32'(l), 32'(NIB));
    check({tag, "_busy_cycles"}, 32'(bn), 32'(NIB + 1));
    @(posedge clk); #1;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    op_full("basic", 16'h1234, 16'h4321, 1'b0);
    op_full("chain", 16'hFFFF, 16'h0001, 1'b0);
    op_full("cin", 16'h0000, 16'hFFFF, 1'b1);
    op_full("b2b", 16'h00FF, 16'h0001, 1'b0);

    // Backpressure: result must hold while new operands are offered.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    hold_e = model(16'h1111, 16'h2222, 1'b0);
    wait_done(lat, busy_n);
    check("bp_latency", 32'(lat), 32'(NIB));
    for (int i = 0; i < 6; i++) begin
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_sum_hold", 32'(sum), 32'(hold_e.sum));
      check("bp_cout_hold", 32'(cout), 32'(hold_e.cout));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset after two RUN cycles aborts the operation.
    send(16'h5555, 16'h1111, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    sb_q.delete();
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    op_full("post_abort", 16'hABCD, 16'h1111, 1'b0);

`ifdef CLA_SEQ_OVF_EN
    op_full("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
    op_full("ovf_neg", 16'h8000, 16'h8000, 1'b0);
    op_full("ovf_none", 16'h0001, 16'h0001, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      op_full("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
